// File: rtl/bch_enc_scheduler_if.sv
// Requester/encoder control bundle for bch_enc_scheduler.
// master = requester/encoder side, slave = scheduler.
interface bch_enc_scheduler_if #(
    parameter int N_REQ  = 2,
    parameter int SEL_SZ = $clog2(N_REQ + 1)
);
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  in_valid;
    logic [N_REQ-1:0]  in_ready;
    logic              out_ready;
    logic              out_valid;
    logic [N_REQ-1:0]  grant;
    logic [SEL_SZ-1:0] sel;
    logic              enc_ce;
    logic              enc_start;
    logic              data_phase;
    logic [N_REQ-1:0]  done;
    logic              abort;
    logic              aborted;

    modport master (
        output req, in_valid, out_ready, abort,
        input  in_ready, out_valid, grant, sel, enc_ce, enc_start, data_phase, done, aborted
    );

    modport slave (
        input  req, in_valid, out_ready, abort,
        output in_ready, out_valid, grant, sel, enc_ce, enc_start, data_phase, done, aborted
    );
endinterface

// File: rtl/bch_enc_scheduler.sv
// Round-robin scheduler sharing one serial BCH encoder among N_REQ requesters.
// Optional frame abort is enabled by defining BCH_ENC_SCHED_ABORT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// DATA  | owner's message bits pass through to the encoder
// ECC   | encoder shifts out parity bits
module bch_enc_scheduler #(
    parameter int N_REQ     = 2,
    parameter int DATA_BITS = 16,
    parameter int ECC_BITS  = 8,
    parameter int SEL_SZ    = $clog2(N_REQ + 1)
) (
    input  logic                clk,
    input  logic                reset,
    bch_enc_scheduler_if.slave  bus
);
    localparam int MAX_BITS = (DATA_BITS > ECC_BITS) ? DATA_BITS : ECC_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ECC  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [SEL_SZ-1:0]  r_sel, w_sel_nxt;
    logic [SEL_SZ-1:0]  r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]   r_done, w_done_nxt;

    logic               w_win_found;
    logic [SEL_SZ-1:0]  w_win_idx;
    logic [N_REQ-1:0]   w_win_oh;
    logic               w_valid_sel;
    logic               w_abort_act;

    logic [N_REQ-1:0]   w_in_ready;
    logic               w_out_valid;
    logic               w_enc_ce;
    logic               w_enc_start;
    logic               w_data_phase;

    // Two passes: requesters above the pointer first, then wrap to 0..ptr.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_oh    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_win_found && bus.req[i] && (i > int'(r_ptr))) begin
                w_win_found = 1'b1;
                w_win_idx   = SEL_SZ'(i);
                w_win_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_win_found && bus.req[i] && (i <= int'(r_ptr))) begin
                w_win_found = 1'b1;
                w_win_idx   = SEL_SZ'(i);
                w_win_oh[i] = 1'b1;
            end
        end
    end

    assign w_valid_sel = |(bus.in_valid & r_grant);

`ifdef BCH_ENC_SCHED_ABORT_EN
    logic r_aborted;
    assign w_abort_act = bus.abort && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) r_aborted <= 1'b0;
        else       r_aborted <= w_abort_act;
    end
    assign bus.aborted = r_aborted;
`else
    assign w_abort_act = 1'b0;
    assign bus.aborted = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_grant_nxt  = r_grant;
        w_sel_nxt    = r_sel;
        w_ptr_nxt    = r_ptr;
        w_done_nxt   = '0;
        w_in_ready   = '0;
        w_out_valid  = 1'b0;
        w_enc_ce     = 1'b0;
        w_enc_start  = 1'b0;
        w_data_phase = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_grant_nxt = w_win_oh;
                    w_sel_nxt   = w_win_idx;
                    w_ptr_nxt   = w_win_idx;
                    w_count_nxt = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_data_phase = 1'b1;
                w_in_ready   = r_grant & {N_REQ{bus.out_ready}};
                w_out_valid  = w_valid_sel;
                w_enc_ce     = w_valid_sel & bus.out_ready;
                w_enc_start  = w_enc_ce & (r_count == '0);
                if (w_enc_ce) begin
                    if (r_count == CNT_W'(DATA_BITS - 1)) begin
                        w_count_nxt = '0;
                        w_state_nxt = S_ECC;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            S_ECC: begin
                w_out_valid = 1'b1;
                w_enc_ce    = bus.out_ready;
                if (w_enc_ce) begin
                    if (r_count == CNT_W'(ECC_BITS - 1)) begin
                        w_done_nxt  = r_grant;
                        w_grant_nxt = '0;
                        w_sel_nxt   = '0;
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_sel_nxt   = '0;
                w_count_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over a coincident last parity bit; ptr keeps the old owner.
        if (w_abort_act) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_sel_nxt   = '0;
            w_count_nxt = '0;
            w_done_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= SEL_SZ'(N_REQ - 1);
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.grant      = r_grant;
    assign bus.sel        = r_sel;
    assign bus.done       = r_done;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.enc_ce     = w_enc_ce;
    assign bus.enc_start  = w_enc_start;
    assign bus.data_phase = w_data_phase;
endmodule
